spi_flash_model_mc: RTL and testbench
=====================================

Name: spi_flash_model_mc

Overview:
- Synthesisable, oversampled SPI NOR flash responder for the SoC system bench; successor to the single-device, single-line behavioural flash hookup.
- Serves NUM_CS independent flash devices behind one shared bus.
- Supports standard, fast and dual-output read; optional quad-output read.
- Samples the SPI pins in the `clk` domain and has a backdoor byte-preload port, so the boot image loads without file I/O.

Parameters:
- NUM_CS, 2, number of chip selects / independent device images (1..4)
- MEM_AW, 16, byte address width per device; MEM_BYTES = 2**MEM_AW
- JEDEC_ID, 24'h20BA18, 3-byte ID returned by 0x9F
- DUMMY_CYC, 8, dummy SPI clocks for 0x0B/0x3B/0x6B

Ports:
- clk  in  1  system clock; must be >= 4x spi_clk
- rst  in  1  synchronous, active-high reset
- spi_clk  in  1  SPI serial clock, mode 0
- spi_cs_n  in  NUM_CS  active-low chip selects
- spi_dq_i  in  4  DQ pin inputs; dq_i[0] = MOSI in single mode
- spi_dq_o  out  4  DQ pin outputs; dq_o[1] = MISO in single mode
- spi_dq_oe  out  4  per-pin output enable
- load_en  in  1  backdoor byte write strobe
- load_addr  in  $clog2(NUM_CS)+MEM_AW  flat backdoor byte address
- load_data  in  8  backdoor byte
- busy  out  1  any chip select active
- err  out  1  sticky protocol error flag

Behaviour:
- Reset: `spi_dq_o` = 0, `spi_dq_oe` = 0, `busy` = 0, `err` = 0, FSM = IDLE.
- Memory contents are not reset; `load_en` writes in the next `clk` edge and is ignored while `busy` = 1.
- Synchronisation: `spi_clk` and `spi_cs_n` pass through 2-flop synchronisers.
  - SPI rise/fall edges are detected on the synchronised `spi_clk`.
  - Input bits are sampled on the detected rise.
  - Output bits update within 1 `clk` of the detected fall.
- Device select:
  - Exactly one `spi_cs_n` bit low selects device k; its image base is k*MEM_BYTES.
  - More than one bit low: FSM goes to IGNORE and `err` is set.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE.
  - IDLE -> CMD on a CS falling edge.
  - CMD: shift 8 bits MSB first.
    - 0x03 -> ADDR, no dummy.
    - 0x0B / 0x3B -> ADDR, then DUMMY.
    - 0x9F -> ID.
    - 0x05 -> STAT.
    - Any other opcode -> IGNORE, `err` set.
  - ADDR: 24 bits, MSB first. Only the low MEM_AW bits are used; upper bits are discarded without error.
  - DUMMY: DUMMY_CYC SPI clocks with all `spi_dq_oe` = 0.
  - DATA:
    - Single mode: `spi_dq_oe` = 4'b0010, 8 falls per byte.
    - Dual mode (0x3B): `spi_dq_oe` = 4'b0011, dq[1] carries bit 7/5/3/1 and dq[0] carries bit 6/4/2/0; 4 falls per byte.
    - The first bit is driven on the first fall after the last ADDR/DUMMY rise.
    - The address post-increments per byte and wraps from MEM_BYTES-1 to 0 within the selected device only.
  - ID: JEDEC_ID MSB first, then repeats.
  - STAT: 8'h00 repeated.
  - IGNORE: all outputs held at OE = 0 until CS is released.
- CS release (all `spi_cs_n` high, synchronised) in any state: FSM -> IDLE and `spi_dq_oe` = 0 on the same `clk` edge. A partial byte is discarded.
- `rst` mid-transaction: FSM -> IDLE and `err` clears. The transaction in flight is not resumed; the master must re-assert CS.
- A new CS fall without an intervening release is impossible by construction; a glitch shorter than the synchroniser is not detected.

Optional Feature:
- Macro: SPI_FLASH_QUAD_EN.
- Defined: opcode 0x6B is accepted (ADDR -> DUMMY -> DATA).
  - DATA uses `spi_dq_oe` = 4'b1111, dq[3:0] = nibble, high nibble first, 2 falls per byte.
- Undefined: 0x6B behaves as an unknown opcode (IGNORE, `err` set), and `spi_dq_oe[3:2]` are tied to 0.

Test Plan:
- Preload device 0 addr 0x0000..0x0003 = 11 22 33 44; CS0 low, send 0x03, addr 0x000000, 32 clocks -> MISO returns 11 22 33 44; `err` = 0.
- Preload device 1 addr 0xFFFF = A5 and addr 0x0000 = 5A; CS1 low, send 0x0B, addr 0x00FFFF, 8 dummy clocks, 16 clocks -> A5 then 5A (wrap); device 0 data is not returned.
- CS0, send 0x3B, addr 0x000000 with bytes 11 22 -> dq[1:0] pairs 00,01,00,01, 00,10,00,10; `spi_dq_oe` = 0011 only during DATA.
- CS0, send 0x9F, 32 clocks -> 20 BA 18 20; CS1 send 0x05 -> 00.
- Drive `spi_cs_n` = 2'b00 -> `err` = 1 and `spi_dq_oe` stays 0; send opcode 0xFF on CS0 -> `err` = 1.
- CS0 read raised after 3 data bits, then re-assert with a new read of addr 0x000001 -> 22 returned; assert `rst` mid-DATA -> `spi_dq_oe` = 0 next edge, `err` = 0.

Source files
------------

// File: rtl/spi_flash_model_mc.sv
// Oversampled multi-device SPI NOR flash responder (read / fast / dual read, JEDEC ID, status).
// Optional quad-output read (0x6B) enabled by defining SPI_FLASH_QUAD_EN.
module spi_flash_model_mc #(
  parameter int unsigned NUM_CS    = 2,
  parameter int unsigned MEM_AW    = 16,
  parameter logic [23:0] JEDEC_ID  = 24'h20BA18,
  parameter int unsigned DUMMY_CYC = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             spi_clk,
  input  logic [NUM_CS-1:0]                spi_cs_n,
  input  logic [3:0]                       spi_dq_i,
  output logic [3:0]                       spi_dq_o,
  output logic [3:0]                       spi_dq_oe,
  input  logic                             load_en,
  input  logic [$clog2(NUM_CS)+MEM_AW-1:0] load_addr,
  input  logic [7:0]                       load_data,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned DW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned MW = DW + MEM_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STAT, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {M_SINGLE, M_DUAL, M_QUAD} mode_t;

  logic [7:0]        r_mem [0:(1<<MW)-1];
  logic [1:0]        r_sclk_sync;
  logic              r_sclk_d;
  logic [NUM_CS-1:0] r_cs_m, r_cs_s;
  logic              r_cs_any_d;
  state_t            r_state;
  mode_t             r_mode;
  logic              r_dummy;
  logic [DW-1:0]     r_dev;
  logic [MEM_AW-1:0] r_sh, r_addr;
  logic [7:0]        r_cnt, r_byte;
  logic [2:0]        r_pos;
  logic [1:0]        r_idx;
  logic [3:0]        r_dq, r_oe;
  logic              r_busy, r_err;

  logic              w_rise, w_fall, w_cs_any, w_cs_fall;
  logic [2:0]        w_nlow;
  logic [DW-1:0]     w_dev;
  logic [7:0]        w_op, w_fresh, w_cur;
  logic [2:0]        w_last;

  // Synchronisers are deliberately not reset so a CS held low through rst is not seen as a new fall.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[0], spi_clk};
    r_sclk_d    <= r_sclk_sync[1];
    r_cs_m      <= spi_cs_n;
    r_cs_s      <= r_cs_m;
  end

  assign w_rise    = r_sclk_sync[1] & ~r_sclk_d;
  assign w_fall    = ~r_sclk_sync[1] & r_sclk_d;
  assign w_cs_any  = (w_nlow != 3'd0);
  assign w_cs_fall = w_cs_any & ~r_cs_any_d;
  assign w_op      = {r_sh[6:0], spi_dq_i[0]};
  assign w_cur     = (r_pos == 3'd0) ? w_fresh : r_byte;

  always_comb begin
    w_nlow = '0;
    w_dev  = '0;
    for (int unsigned k = 0; k < NUM_CS; k++) begin
      if (!r_cs_s[k]) begin
        w_nlow = w_nlow + 3'd1;
        w_dev  = DW'(k);
      end
    end
  end

  always_comb begin
    w_fresh = '0;
    case (r_state)
      S_DATA: w_fresh = r_mem[{r_dev, r_addr}];
      S_ID: begin
        case (r_idx)
          2'd0:    w_fresh = JEDEC_ID[23:16];
          2'd1:    w_fresh = JEDEC_ID[15:8];
          default: w_fresh = JEDEC_ID[7:0];
        endcase
      end
      default: w_fresh = '0;
    endcase
  end

  always_comb begin
    case (r_mode)
      M_DUAL:  w_last = 3'd3;
      M_QUAD:  w_last = 3'd1;
      default: w_last = 3'd7;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_en && !r_busy) r_mem[MW'(load_addr)] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= M_SINGLE;
      r_dummy    <= 1'b0;
      r_dev      <= '0;
      r_sh       <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_pos      <= '0;
      r_idx      <= '0;
      r_dq       <= '0;
      r_oe       <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cs_any_d <= 1'b1;
    end else begin
      r_cs_any_d <= w_cs_any;
      r_busy     <= w_cs_any;
      if (!w_cs_any) begin
        r_state <= S_IDLE;
        r_oe    <= '0;
        r_dq    <= '0;
      end else if (w_nlow > 3'd1) begin
        r_state <= S_IGNORE;
        r_err   <= 1'b1;
        r_oe    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state <= S_CMD;
              r_dev   <= w_dev;
              r_cnt   <= '0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              r_sh  <= {r_sh[MEM_AW-2:0], spi_dq_i[0]};
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == 8'd7) begin
                r_cnt  <= '0;
                r_pos  <= '0;
                r_idx  <= '0;
                r_mode <= M_SINGLE;
                case (w_op)
                  8'h03: begin r_state <= S_ADDR; r_dummy <= 1'b0; end
                  8'h0B: begin r_state <= S_ADDR; r_dummy <= 1'b1; end
                  8'h3B: begin r_state <= S_ADDR; r_dummy <= 1'b1; r_mode <= M_DUAL; end
`ifdef SPI_FLASH_QUAD_EN
                  8'h6B: begin r_state <= S_ADDR; r_dummy <= 1'b1; r_mode <= M_QUAD; end
`endif
                  8'h9F:   r_state <= S_ID;
                  8'h05:   r_state <= S_STAT;
                  default: begin r_state <= S_IGNORE; r_err <= 1'b1; end
                endcase
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_sh  <= {r_sh[MEM_AW-2:0], spi_dq_i[0]};
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == 8'd23) begin
                r_addr  <= {r_sh[MEM_AW-2:0], spi_dq_i[0]};
                r_cnt   <= '0;
                r_state <= r_dummy ? S_DUMMY : S_DATA;
              end
            end
          end
          S_DUMMY: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == 8'(DUMMY_CYC - 1)) r_state <= S_DATA;
            end
          end
          S_DATA, S_ID, S_STAT: begin
            // A new byte is fetched on the first fall of each byte; the address/ID index advances then.
            if (w_fall) begin
              r_pos <= (r_pos == w_last) ? 3'd0 : r_pos + 3'd1;
              if (r_pos == 3'd0) begin
                if (r_state == S_DATA) r_addr <= r_addr + MEM_AW'(1);
                if (r_state == S_ID)   r_idx  <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
              end
              case (r_mode)
                M_DUAL: begin
                  r_dq   <= {2'b00, w_cur[7:6]};
                  r_oe   <= 4'b0011;
                  r_byte <= w_cur << 2;
                end
                M_QUAD: begin
                  r_dq   <= w_cur[7:4];
                  r_oe   <= 4'b1111;
                  r_byte <= w_cur << 4;
                end
                default: begin
                  r_dq   <= {2'b00, w_cur[7], 1'b0};
                  r_oe   <= 4'b0010;
                  r_byte <= w_cur << 1;
                end
              endcase
            end
          end
          default: r_oe <= '0;
        endcase
      end
    end
  end

`ifdef SPI_FLASH_QUAD_EN
  assign spi_dq_o  = r_dq;
  assign spi_dq_oe = r_oe;
  logic w_unused;
  assign w_unused = ^spi_dq_i[3:1];
`else
  assign spi_dq_o  = {2'b00, r_dq[1:0]};
  assign spi_dq_oe = {2'b00, r_oe[1:0]};
  logic w_unused;
  assign w_unused = ^{spi_dq_i[3:1], r_dq[3:2], r_oe[3:2]};
`endif

  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_spi_flash_model_mc.sv
// Directed + randomized bench for spi_flash_model_mc with a byte-array reference image.
module tb_spi_flash_model_mc;
  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst, spi_clk;
  logic [1:0]  spi_cs_n;
  logic [3:0]  spi_dq_i, spi_dq_o, spi_dq_oe;
  logic        load_en;
  logic [16:0] load_addr;
  logic [7:0]  load_data;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int oe_bad;
  logic [7:0] ref_mem [0:131071];
  logic [7:0] rx_q [$];

  spi_flash_model_mc #(
    .NUM_CS(2), .MEM_AW(16), .JEDEC_ID(24'h20BA18), .DUMMY_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_dq_i(spi_dq_i), .spi_dq_o(spi_dq_o), .spi_dq_oe(spi_dq_oe),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int dev, input int a);
    return ref_mem[dev * 65536 + (a & 32'hFFFF)];
  endfunction

  task automatic load(input int a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = 17'(a); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    ref_mem[a] = d;
    #2;
  endtask

  task automatic spi_cycle(input logic [3:0] dq, output logic [3:0] o, output logic [3:0] oe);
    spi_dq_i = dq;
    #HALF;
    o  = spi_dq_o;
    oe = spi_dq_oe;
    spi_clk = 1'b1;
    #HALF;
    spi_clk = 1'b0;
  endtask

  // Leaves CS asserted; bytes received land in rx_q, wrong data-phase OE samples in oe_bad.
  task automatic txn(input int dev, input logic [7:0] op, input int naddr, input logic [23:0] addr,
                     input int ndummy, input int width, input int nbytes, input logic [3:0] exp_oe);
    logic [3:0] o, oe;
    logic [7:0] b;
    int pre_bad = 0;
    rx_q.delete();
    oe_bad = 0;
    spi_cs_n = 2'b11;
    spi_cs_n[dev] = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_cycle({3'b000, op[i]}, o, oe);
      if (oe !== 4'b0000) pre_bad++;
    end
    for (int i = 0; i < naddr; i++) begin
      spi_cycle({3'b000, addr[23-i]}, o, oe);
      if (oe !== 4'b0000) pre_bad++;
    end
    for (int i = 0; i < ndummy; i++) begin
      spi_cycle(4'b0000, o, oe);
      if (oe !== 4'b0000) pre_bad++;
    end
    for (int n = 0; n < nbytes; n++) begin
      b = '0;
      for (int c = 0; c < 8 / width; c++) begin
        spi_cycle(4'b0000, o, oe);
        if (oe !== exp_oe) oe_bad++;
        case (width)
          1:       b = {b[6:0], o[1]};
          2:       b = {b[5:0], o[1], o[0]};
          default: b = {b[3:0], o};
        endcase
      end
      rx_q.push_back(b);
    end
    check("pre_data_oe", pre_bad, 0);
    if (nbytes > 0) check("data_oe", oe_bad, 0);
  endtask

  task automatic release_cs();
    #HALF;
    spi_cs_n = 2'b11;
    #(4 * HALF);
    check("oe_after_release", spi_dq_oe, 4'b0000);
    check("busy_after_release", busy, 1'b0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  initial begin
    logic [3:0] o, oe;
    int bad;
    rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 2'b11; spi_dq_i = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_dq_o", spi_dq_o, 4'b0000);
    check("rst_dq_oe", spi_dq_oe, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;

    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
    load(65536 + 16'hFFFF, 8'hA5); load(65536, 8'h5A);

    // standard read
    txn(0, 8'h03, 24, 24'h000000, 0, 1, 4, 4'b0010);
    check("rd03_b0", rx_q[0], 8'h11);
    check("rd03_b1", rx_q[1], 8'h22);
    check("rd03_b2", rx_q[2], 8'h33);
    check("rd03_b3", rx_q[3], 8'h44);
    check("rd03_err", err, 1'b0);
    release_cs();

    // fast read with wrap inside device 1
    txn(1, 8'h0B, 24, 24'h00FFFF, 8, 1, 2, 4'b0010);
    check("rd0B_b0", rx_q[0], 8'hA5);
    check("rd0B_wrap", rx_q[1], 8'h5A);
    release_cs();

    // dual read
    txn(0, 8'h3B, 24, 24'h000000, 8, 2, 2, 4'b0011);
    check("rd3B_b0", rx_q[0], 8'h11);
    check("rd3B_b1", rx_q[1], 8'h22);
    release_cs();

    txn(0, 8'h9F, 0, 24'h0, 0, 1, 4, 4'b0010);
    check("id_b0", rx_q[0], 8'h20);
    check("id_b1", rx_q[1], 8'hBA);
    check("id_b2", rx_q[2], 8'h18);
    check("id_rep", rx_q[3], 8'h20);
    release_cs();
    txn(1, 8'h05, 0, 24'h0, 0, 1, 1, 4'b0010);
    check("stat", rx_q[0], 8'h00);
    release_cs();

    // two chip selects at once; backdoor writes must be ignored while busy
    spi_cs_n = 2'b00;
    #(4 * HALF);
    check("multi_cs_busy", busy, 1'b1);
    check("multi_cs_err", err, 1'b1);
    @(negedge clk);
    load_en = 1'b1; load_addr = 17'd0; load_data = 8'hEE;
    @(negedge clk);
    load_en = 1'b0;
    #2;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      spi_cycle(4'b0001, o, oe);
      if (oe !== 4'b0000) bad++;
    end
    check("multi_cs_oe", bad, 0);
    release_cs();
    check("err_sticky", err, 1'b1);
    txn(0, 8'h03, 24, 24'h000000, 0, 1, 1, 4'b0010);
    check("load_ignored_busy", rx_q[0], 8'h11);
    release_cs();
    pulse_rst();
    check("err_cleared", err, 1'b0);

    // unknown opcode
    txn(0, 8'hFF, 0, 24'h0, 0, 1, 0, 4'b0000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      spi_cycle(4'b0000, o, oe);
      if (oe !== 4'b0000) bad++;
    end
    check("bad_op_oe", bad, 0);
    check("bad_op_err", err, 1'b1);
    release_cs();
    pulse_rst();

`ifdef SPI_FLASH_QUAD_EN
    txn(0, 8'h6B, 24, 24'h000000, 8, 4, 2, 4'b1111);
    check("quad_b0", rx_q[0], 8'h11);
    check("quad_b1", rx_q[1], 8'h22);
    check("quad_err", err, 1'b0);
    release_cs();
`else
    txn(0, 8'h6B, 24, 24'h000000, 8, 1, 0, 4'b0000);
    check("quad_off_err", err, 1'b1);
    release_cs();
    pulse_rst();
`endif

    // partial byte discarded, then a fresh read
    txn(0, 8'h03, 24, 24'h000000, 0, 1, 0, 4'b0010);
    for (int i = 0; i < 3; i++) spi_cycle(4'b0000, o, oe);
    release_cs();
    txn(0, 8'h03, 24, 24'h000001, 0, 1, 1, 4'b0010);
    check("reread_addr1", rx_q[0], 8'h22);
    release_cs();

    // rst in the middle of DATA, with err previously set
    txn(0, 8'hFF, 0, 24'h0, 0, 1, 0, 4'b0000);
    release_cs();
    check("err_before_rst", err, 1'b1);
    txn(0, 8'h03, 24, 24'h000002, 0, 1, 1, 4'b0010);
    check("pre_rst_byte", rx_q[0], 8'h33);
    spi_cycle(4'b0000, o, oe);
    spi_cycle(4'b0000, o, oe);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_oe", spi_dq_oe, 4'b0000);
    check("rst_mid_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      spi_cycle(4'b0000, o, oe);
      if (oe !== 4'b0000) bad++;
    end
    check("no_resume_oe", bad, 0);
    release_cs();

    // randomized reads against the reference image
    for (int t = 0; t < 10; t++) begin
      int dev, n, kind, width, ndummy;
      logic [23:0] a;
      logic [7:0] op;
      dev  = int'($urandom_range(0, 1));
      n    = int'($urandom_range(1, 4));
      kind = int'($urandom_range(0, 2));
      a    = 24'($urandom);
      if ($urandom_range(0, 1) == 1) a[15:0] = 16'hFFFE;
      for (int i = 0; i < n; i++)
        load(dev * 65536 + ((int'(a[15:0]) + i) & 32'hFFFF), 8'($urandom));
      op     = (kind == 0) ? 8'h03 : (kind == 1) ? 8'h0B : 8'h3B;
      ndummy = (kind == 0) ? 0 : 8;
      width  = (kind == 2) ? 2 : 1;
      txn(dev, op, 24, a, ndummy, width, n, (kind == 2) ? 4'b0011 : 4'b0010);
      for (int i = 0; i < n; i++)
        check($sformatf("rand%0d_b%0d", t, i), rx_q[i], exp_rd(dev, int'(a[15:0]) + i));
      check($sformatf("rand%0d_err", t), err, 1'b0);
      release_cs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
